grid_scan: RTL and testbench
============================

GRID_SCAN -- requirements
Module: grid_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per sclk half-period (legal range 1..255).
REQ-002 SHALL have parameter DWELL, default 2000, meaning clk cycles each row is displayed (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port enable  input  1  scan run request.
REQ-006 SHALL have port grid_col  input  16  lit-column pattern for the row on grid_row (bit 15 = leftmost).
REQ-007 SHALL have port grid_row  output  16  row index presented to the pattern generator (value 0..15, upper bits 0).
REQ-008 SHALL have port sclk  output  1  shift-register serial clock.
REQ-009 SHALL have port sdata  output  1  shift-register serial data.
REQ-010 SHALL have port rclk  output  1  shift-register storage latch.
REQ-011 SHALL have port oe_n  output  1  display output enable, active-low.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse when row 0 is captured.

Function
REQ-013 SHALL implement states IDLE, LOAD, CAPTURE, SHIFT, LATCH, DISPLAY.
REQ-014 IDLE: oe_n=1, sclk=0, rclk=0; go to LOAD when enable=1.
REQ-015 LOAD: drive grid_row with the current row; hold exactly 1 cycle so grid_col settles; go to CAPTURE.
REQ-016 CAPTURE: load the 32-bit shift word in 1 cycle; go to SHIFT.
REQ-017 Shift word SHALL be {grid_col[15:0], ~(16'h8000 >> row)} (row select active-low, row 0 = bit 15).
REQ-018 SHIFT: send 32 bits MSB first; sdata changes only while sclk=0; each sclk low and high phase lasts CLK_DIV cycles; exactly 32 rising sclk edges; sclk ends at 0.
REQ-019 oe_n SHALL stay at its DISPLAY value during SHIFT (the previous row remains visible while the next row shifts).
REQ-020 LATCH: oe_n=1 and rclk=1 for CLK_DIV cycles, then rclk=0; go to DISPLAY.
REQ-021 DISPLAY: oe_n=0 for DWELL cycles; then advance row by 1 (15 wraps to 0) and go to LOAD.
REQ-022 If enable=0 at the end of DISPLAY, SHALL go to IDLE instead of LOAD; the row counter still advances. enable SHALL be ignored in all other states (the current row always completes).
REQ-023 frame_start SHALL be 1 only in the CAPTURE cycle for row 0.
REQ-024 One full row period SHALL take 1 + 1 + 64*CLK_DIV + CLK_DIV + DWELL cycles.
REQ-025 Counters SHALL be sized for the maximum legal parameter values, with no overflow at any legal value.

Reset
REQ-026 While reset_n=0 at a clk edge: state=IDLE, row=0, grid_row=0, sclk=0, sdata=0, rclk=0, oe_n=1, frame_start=0, shift word and counters cleared.
REQ-027 Reset asserted mid-SHIFT or mid-DISPLAY SHALL abort immediately; after release, scanning restarts at row 0 with a full 32-bit shift.

Configuration
REQ-028 With macro GRID_SCAN_BRIGHTNESS_EN defined: add port brightness (input, 4 bits); in DISPLAY, oe_n=0 only for the first (DWELL*brightness)/15 cycles of the row, else 1; brightness is sampled at CAPTURE; brightness=0 keeps oe_n=1 for the whole row.
REQ-029 Without GRID_SCAN_BRIGHTNESS_EN: there is no brightness port, and oe_n=0 for all DWELL cycles (REQ-021).

Verification
REQ-030 Reset held 5 cycles, enable=1, CLK_DIV=1, DWELL=4, grid_col=16'hA5A5 -> serial capture gives 32'hA5A5_7FFF; rclk pulses once; row period is 71 cycles.
REQ-031 Run 16 rows with grid_col = 16'h0001<<row -> row 15 word is {16'h8000, 16'hFFFE}; next row is 0; frame_start pulses once per 16 rows.
REQ-032 Deassert enable mid-SHIFT of row 3 -> row 3 completes LATCH and DISPLAY; block enters IDLE with oe_n=1 and grid_row=4; re-enable -> resumes at row 4.
REQ-033 Assert reset_n=0 at bit 10 of SHIFT for row 7 -> next cycle all outputs take reset values; after release, first word shifted is for row 0.
REQ-034 GRID_SCAN_BRIGHTNESS_EN defined, DWELL=15, brightness=5 -> oe_n low for exactly 5 of 15 DISPLAY cycles; brightness=0 -> oe_n never low.
REQ-035 CLK_DIV=3 -> every sclk high and low phase is 3 cycles; sdata is stable across every sclk rising edge.

Source files
------------

// File: rtl/grid_scan.sv
// grid_scan: row-scanned LED grid driver feeding a chain of two 16-bit shift
// registers (column data first, then active-low row select).
//
// Each row goes through five phases:
//   present the row index, capture the 32-bit word, shift it out serially,
//   pulse the storage latch, then display it for DWELL cycles.
// The previous row stays lit while the next row is loaded and shifted.
//
// Parameters
//   CLK_DIV  clk cycles per sclk half-period (1..255)
//   DWELL    clk cycles each row is displayed (1..65535)
//
// Ports
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   enable       scan run request; only sampled at the end of DISPLAY
//   grid_col     lit-column pattern for grid_row (bit 15 = leftmost)
//   grid_row     current row index 0..15 (upper bits 0)
//   sclk         shift-register serial clock
//   sdata        shift-register serial data, MSB first
//   rclk         shift-register storage latch
//   oe_n         display output enable, active-low
//   frame_start  one-cycle pulse when row 0 is captured
//   brightness   (only with GRID_SCAN_BRIGHTNESS_EN) 4-bit duty, sampled at
//                capture; row lit for (DWELL*brightness)/15 cycles
//
// Optional feature macro: GRID_SCAN_BRIGHTNESS_EN
//
// state   | meaning
// IDLE    | display off, waiting for enable
// LOAD    | grid_row driven, one cycle for grid_col to settle
// CAPTURE | build the 32-bit shift word
// SHIFT   | 32 bits out on sclk/sdata, previous row still shown
// LATCH   | rclk high for CLK_DIV cycles, display blanked
// DISPLAY | row lit for DWELL cycles, then next row

module grid_scan #(
   parameter int CLK_DIV = 2,
   parameter int DWELL   = 2000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [15:0] grid_col,
`ifdef GRID_SCAN_BRIGHTNESS_EN
   input  logic [3:0]  brightness,
`endif
   output logic [15:0] grid_row,
   output logic        sclk,
   output logic        sdata,
   output logic        rclk,
   output logic        oe_n,
   output logic        frame_start
);

   localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
   localparam logic [15:0] DWELL_W  = 16'(DWELL);
   localparam logic [15:0] DWELL_M1 = 16'(DWELL - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CAPTURE,
      SHIFT,
      LATCH,
      DISPLAY
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  row;
   logic [31:0] word;
   logic [15:0] tmr;      // down-counter shared by SHIFT phases, LATCH and DISPLAY
   logic [5:0]  hp;       // sclk half-periods remaining, odd = low phase
   logic        oe_last;  // oe_n seen on the last DISPLAY cycle
   logic        tc;
   logic        disp_oe_n;

`ifdef GRID_SCAN_BRIGHTNESS_EN
   logic [19:0] on_left;
   logic [19:0] on_load;

   assign on_load   = (20'(DWELL_W) * 20'(brightness)) / 20'd15;
   assign disp_oe_n = (on_left == 20'd0);
`else
   assign disp_oe_n = 1'b0;
`endif

   assign tc          = (tmr == 16'd0);
   assign grid_row    = {12'h000, row};
   assign sdata       = word[31];
   assign sclk        = (state == SHIFT) && !hp[0];
   assign rclk        = (state == LATCH);
   assign frame_start = (state == CAPTURE) && (row == 4'd0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         row     <= 4'd0;
         word    <= 32'd0;
         tmr     <= 16'd0;
         hp      <= 6'd0;
         oe_last <= 1'b1;
`ifdef GRID_SCAN_BRIGHTNESS_EN
         on_left <= 20'd0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               oe_last <= 1'b1;
            end
            CAPTURE: begin
               word <= {grid_col, ~(16'h8000 >> row)};
               tmr  <= DIV_M1;
               hp   <= 6'd63;
`ifdef GRID_SCAN_BRIGHTNESS_EN
               on_left <= on_load;
`endif
            end
            SHIFT: begin
               if (tc) begin
                  tmr <= DIV_M1;
                  hp  <= hp - 6'd1;
                  // advance data as sclk falls so it is stable through the next high phase
                  if (!hp[0]) word <= {word[30:0], 1'b0};
               end else begin
                  tmr <= tmr - 16'd1;
               end
            end
            LATCH: begin
               if (tc) tmr <= DWELL_M1;
               else    tmr <= tmr - 16'd1;
            end
            DISPLAY: begin
               oe_last <= oe_n;
`ifdef GRID_SCAN_BRIGHTNESS_EN
               if (on_left != 20'd0) on_left <= on_left - 20'd1;
`endif
               if (tc) row <= row + 4'd1;
               else    tmr <= tmr - 16'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      oe_n      = 1'b1;
      case (state)
         IDLE: begin
            if (enable) state_nxt = LOAD;
         end
         LOAD: begin
            oe_n      = oe_last;
            state_nxt = CAPTURE;
         end
         CAPTURE: begin
            oe_n      = oe_last;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            oe_n = oe_last;
            if (tc && hp == 6'd0) state_nxt = LATCH;
         end
         LATCH: begin
            if (tc) state_nxt = DISPLAY;
         end
         DISPLAY: begin
            oe_n = disp_oe_n;
            if (tc) state_nxt = enable ? LOAD : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_grid_scan.sv
// Directed bench for grid_scan: a CLK_DIV=1/DWELL=4 instance for word,
// period, row-sequencing, enable and reset behaviour; a CLK_DIV=3 instance
// for sclk phase timing; a DWELL=15 instance for brightness when
// GRID_SCAN_BRIGHTNESS_EN is defined.

module tb_grid_scan;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        pat_mode = 1'b0;

   logic [15:0] grid_col, grid_row;
   logic        sclk, sdata, rclk, oe_n, frame_start;

   logic [15:0] grid_col3, grid_row3;
   logic        sclk3, sdata3, rclk3, oe_n3, frame_start3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign grid_col  = pat_mode ? (16'h0001 << grid_row[3:0]) : 16'hA5A5;
   assign grid_col3 = 16'h3C5A;

   grid_scan #(.CLK_DIV(1), .DWELL(4)) u_dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .grid_col(grid_col),
`ifdef GRID_SCAN_BRIGHTNESS_EN
      .brightness(4'd15),
`endif
      .grid_row(grid_row), .sclk(sclk), .sdata(sdata), .rclk(rclk),
      .oe_n(oe_n), .frame_start(frame_start)
   );

   grid_scan #(.CLK_DIV(3), .DWELL(4)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .grid_col(grid_col3),
`ifdef GRID_SCAN_BRIGHTNESS_EN
      .brightness(4'd15),
`endif
      .grid_row(grid_row3), .sclk(sclk3), .sdata(sdata3), .rclk(rclk3),
      .oe_n(oe_n3), .frame_start(frame_start3)
   );

`ifdef GRID_SCAN_BRIGHTNESS_EN
   logic [3:0]  brt = 4'd5;
   logic [15:0] grid_rowb;
   logic        sclkb, sdatab, rclkb, oe_nb, frame_startb;
   int          latchb_cnt = 0, lowb_acc = 0, lowb_last = -1;
   logic        p_rclkb = 1'b0;

   grid_scan #(.CLK_DIV(1), .DWELL(15)) u_dutb (
      .clk(clk), .reset_n(reset_n), .enable(enable), .grid_col(16'hFFFF),
      .brightness(brt),
      .grid_row(grid_rowb), .sclk(sclkb), .sdata(sdatab), .rclk(rclkb),
      .oe_n(oe_nb), .frame_start(frame_startb)
   );

   always @(negedge clk) begin
      if (rclkb && !p_rclkb) begin
         lowb_last = lowb_acc;
         lowb_acc  = 0;
         latchb_cnt++;
      end
      if (!oe_nb) lowb_acc++;
      p_rclkb = rclkb;
   end
`endif

   // serial receiver model for u_dut
   logic [31:0] sreg = 32'd0, latched = 32'd0;
   logic        p_sclk = 1'b0, p_rclk = 1'b0;
   int cyc = 0, bits1 = 0, bits_at_latch = 0, latch_cnt = 0;
   int last_latch_cyc = 0, period = 0, rclk_run = 0, rclk_len = 0;
   int oe_low_acc = 0, oe_low_last = 0, fs_cnt = 0;

   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         bits1  = 0;
         p_sclk = 1'b0;
         p_rclk = 1'b0;
      end else begin
         if (sclk && !p_sclk) begin
            sreg = {sreg[30:0], sdata};
            bits1++;
         end
         if (rclk && !p_rclk) begin
            latched        = sreg;
            latch_cnt++;
            period         = cyc - last_latch_cyc;
            last_latch_cyc = cyc;
            oe_low_last    = oe_low_acc;
            oe_low_acc     = 0;
            bits_at_latch  = bits1;
            bits1          = 0;
            rclk_run       = 0;
         end
         if (rclk) rclk_run++;
         if (!rclk && p_rclk) rclk_len = rclk_run;
         if (!oe_n) oe_low_acc++;
         if (frame_start) fs_cnt++;
         p_sclk = sclk;
         p_rclk = rclk;
      end
   end

   // sclk phase and data-stability watcher for u_dut3
   logic p_sclk3 = 1'b0, p_sdata3 = 1'b0, p_rclk3 = 1'b0;
   int   err3 = 0, rises3 = 0, highs3 = 0, high_run3 = 0, low_run3 = 0;

   always @(negedge clk) begin
      if (!reset_n) begin
         rises3  = 0;
         p_sclk3 = 1'b0;
         p_rclk3 = 1'b0;
      end else begin
         if (sclk3 && !p_sclk3) begin
            if (sdata3 != p_sdata3) err3++;
            if (rises3 != 0 && low_run3 != 3) err3++;
            rises3++;
            high_run3 = 0;
         end
         if (!sclk3 && p_sclk3) begin
            if (high_run3 != 3) err3++;
            highs3++;
            low_run3 = 0;
         end
         if (sclk3) high_run3++;
         else       low_run3++;
         if (rclk3 && !p_rclk3) rises3 = 0;
         p_sclk3 = sclk3;
         p_rclk3 = rclk3;
      end
      p_sdata3 = sdata3;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_latch(input string tag);
      int n0;
      n0 = latch_cnt;
      for (int k = 0; k < 600 && latch_cnt == n0; k++) tick();
      chk({tag, "_latches"}, 32'(latch_cnt - n0), 32'd1);
   endtask

   logic [15:0] ecol, esel;
   logic        hit;

   initial begin
      // reset held 5 cycles
      for (int i = 0; i < 5; i++) tick();
      chk("reset_outs", {11'd0, grid_row, sclk, sdata, rclk, oe_n, frame_start},
          {11'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

      reset_n = 1'b1;
      enable  = 1'b1;

      wait_latch("row0");
      chk("row0_word", latched, 32'hA5A5_7FFF);
      chk("row0_bits", 32'(bits_at_latch), 32'd32);
      fs_cnt = 0;

      wait_latch("row1");
      chk("row1_word", latched, 32'hA5A5_BFFF);
      chk("row_period", 32'(period), 32'd71);
      chk("rclk_width", 32'(rclk_len), 32'd1);
      chk("oe_low_per_row", 32'(oe_low_last), 32'd70);

      // walking-one columns over a full frame
      pat_mode = 1'b1;
      for (int r = 2; r <= 16; r++) begin
         wait_latch("walk");
         ecol = 16'h0001 << (r % 16);
         esel = ~(16'h8000 >> (r % 16));
         chk($sformatf("walk_row%0d", r % 16), latched, {ecol, esel});
         if (r == 15) chk("row15_word", latched, 32'h8000_FFFE);
      end
      chk("wrap_row0_word", latched, 32'h0001_7FFF);
      chk("frame_start_per_16", 32'(fs_cnt), 32'd1);
      chk("walk_period", 32'(period), 32'd71);

      // drop enable during the shift of row 3
      wait_latch("row1b");
      wait_latch("row2b");
      hit = 1'b0;
      for (int k = 0; k < 300 && !hit; k++) begin
         if (grid_row == 16'd3 && sclk) hit = 1'b1;
         else tick();
      end
      chk("row3_shift_seen", {31'd0, hit}, 32'd1);
      enable = 1'b0;
      wait_latch("row3");
      chk("row3_word", latched, 32'h0008_EFFF);
      for (int i = 0; i < 12; i++) tick();
      chk("idle_oe_n", {31'd0, oe_n}, 32'd1);
      chk("idle_grid_row", {16'd0, grid_row}, 32'd4);
      begin
         int n0;
         n0 = latch_cnt;
         for (int i = 0; i < 100; i++) tick();
         chk("idle_no_latch", 32'(latch_cnt - n0), 32'd0);
      end
      enable = 1'b1;
      wait_latch("row4");
      chk("resume_row4_word", latched, 32'h0010_F7FF);

      chk("div3_phase_err", 32'(err3), 32'd0);
      chk("div3_highs_seen", {31'd0, highs3 >= 64}, 32'd1);

      // reset at bit 10 of row 7's shift
      wait_latch("row5");
      wait_latch("row6");
      hit = 1'b0;
      for (int k = 0; k < 300 && !hit; k++) begin
         if (grid_row == 16'd7 && bits1 == 10) hit = 1'b1;
         else tick();
      end
      chk("row7_bit10_seen", {31'd0, hit}, 32'd1);
      reset_n = 1'b0;
      tick();
      chk("abort_outs", {11'd0, grid_row, sclk, sdata, rclk, oe_n, frame_start},
          {11'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      tick();
      tick();
      reset_n = 1'b1;
      wait_latch("restart");
      chk("restart_word", latched, 32'h0001_7FFF);
      chk("restart_bits", 32'(bits_at_latch), 32'd32);

`ifdef GRID_SCAN_BRIGHTNESS_EN
      begin
         int n0;
         n0 = latchb_cnt;
         for (int i = 0; i < 400 && latchb_cnt < n0 + 3; i++) tick();
         chk("bright5_low", 32'(lowb_last), 32'd5);
         brt = 4'd0;
         n0 = latchb_cnt;
         for (int i = 0; i < 400 && latchb_cnt < n0 + 3; i++) tick();
         chk("bright0_low", 32'(lowb_last), 32'd0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
